// File: rtl/lm07_sched_pkg.sv
// Shared definitions for the LM07 sample scheduler: FSM state encoding,
// sample width, timeout fill value and a counter-width helper.
package lm07_sched_pkg;

   localparam int DATA_W = 8;

   // Sample returned to the winner when a read is aborted on timeout.
   localparam logic [DATA_W-1:0] TMO_FILL = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_START   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DELIVER = 3'd4,
      ST_GAP     = 3'd5
   } sched_state_t;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int sched_clog2(input int value);
      int r;
      r = 1;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/lm07_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner search starting at the
// pointer, with the pointer moving past the winner whenever adv is high.
module lm07_rr_arbiter
   import lm07_sched_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            adv,
   output logic [NREQ-1:0] win,
   output logic            any
);

   localparam int IW = sched_clog2(NREQ);

   logic [IW-1:0] ptr;
   logic [IW-1:0] win_idx;

   // Pick the first active request at or after the pointer, wrapping around.
   always_comb begin
      int j;
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      j       = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(ptr) + i) % NREQ;
         if (!any && req[j]) begin
            any     = 1'b1;
            win[j]  = 1'b1;
            win_idx = IW'(j);
         end
      end
   end

   // Move the pointer one past the granted requester so it gets lowest priority next.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (adv && any) begin
         ptr <= IW'((int'(win_idx) + 1) % NREQ);
      end
   end

endmodule

// File: rtl/lm07_sample_sched.sv
// LM07 sample scheduler: shares one SPI read engine between NREQ requesters
// and a periodic auto-sample slot. Sequence per read is
// IDLE -> ARB -> START -> WAIT -> DELIVER -> GAP -> IDLE.
// Optional feature: define SCHED_TIMEOUT_EN to abort a read after TIMEOUT
// cycles in WAIT, pulse ERR and deliver TMO_FILL instead of engine data.
module lm07_sample_sched
   import lm07_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int PERIOD  = 1000,
   parameter int GAP     = 18,
   parameter int TIMEOUT = 64
) (
   input  logic              SYSCLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ,
   output logic [NREQ-1:0]   GNT,
   output logic [NREQ-1:0]   RSP_VALID,
   output logic [DATA_W-1:0] RSP_DATA,
   output logic              AUTO_VALID,
   output logic              AUTO_MISS,
   output logic              ERR,
   output logic              RD_START,
   input  logic              RD_DONE,
   input  logic [DATA_W-1:0] RD_DATA
);

   localparam int PCW = sched_clog2(PERIOD);
   localparam int GCW = sched_clog2(GAP);

   sched_state_t      state;
   sched_state_t      state_nxt;

   logic [PCW-1:0]    pcnt;
   logic              wrap;
   logic              auto_pend;
   logic              auto_clr;
   logic              auto_miss;
   logic              auto_win;
   logic [NREQ-1:0]   gnt_q;
   logic [GCW-1:0]    gap_cnt;
   logic [DATA_W-1:0] rsp_data;
   logic              tmo;

   logic [NREQ-1:0]   arb_win;
   logic              arb_any;
   logic              arb_adv;

   // The pointer only advances when a requester (not the auto slot) wins.
   assign arb_adv  = (state == ST_ARB) && !auto_pend;
   assign auto_clr = (state == ST_ARB) && auto_pend;
   assign wrap     = (pcnt == PCW'(PERIOD - 1));

   lm07_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk (SYSCLK),
      .rst (RST),
      .req (REQ),
      .adv (arb_adv),
      .win (arb_win),
      .any (arb_any)
   );

   // Free-running period counter; one pending auto request at most, overrun is sticky.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         pcnt      <= '0;
         auto_pend <= 1'b0;
         auto_miss <= 1'b0;
      end else begin
         pcnt <= wrap ? '0 : pcnt + 1'b1;
         if (wrap) begin
            auto_pend <= 1'b1;
         end else if (auto_clr) begin
            auto_pend <= 1'b0;
         end
         if (wrap && auto_pend && !auto_clr) begin
            auto_miss <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Per-transaction control: winner latch, gap countdown.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         gnt_q    <= '0;
         auto_win <= 1'b0;
         gap_cnt  <= '0;
      end else begin
         case (state)
            ST_ARB: begin
               auto_win <= auto_pend;
               gnt_q    <= auto_pend ? '0 : arb_win;
            end
            ST_DELIVER: begin
               gnt_q   <= '0;
               gap_cnt <= GCW'(GAP - 1);
            end
            ST_GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Sample capture; the value stays on RSP_DATA until the next delivery.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         rsp_data <= '0;
      end else if (state == ST_WAIT) begin
         if (RD_DONE) begin
            rsp_data <= RD_DATA;
         end else if (tmo) begin
            rsp_data <= TMO_FILL;
         end
      end
   end

`ifdef SCHED_TIMEOUT_EN
   localparam int TCW = sched_clog2(TIMEOUT);

   logic [TCW-1:0] wcnt;
   logic           err_q;

   assign tmo = (state == ST_WAIT) && !RD_DONE && (wcnt == TCW'(TIMEOUT - 1));
   assign ERR = err_q;

   // Count cycles spent in WAIT; ERR is registered so it lines up with DELIVER.
   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         wcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= tmo;
         if (state == ST_WAIT) begin
            wcnt <= wcnt + 1'b1;
         end else begin
            wcnt <= '0;
         end
      end
   end
`else
   assign tmo = 1'b0;
   assign ERR = 1'b0;
`endif

   // Next-state logic and Moore-style outputs; GNT is shown during ARB so it
   // appears the cycle after the request is seen.
   always_comb begin
      state_nxt  = state;
      GNT        = '0;
      RSP_VALID  = '0;
      AUTO_VALID = 1'b0;
      RD_START   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (auto_pend || (|REQ)) state_nxt = ST_ARB;
         end
         ST_ARB: begin
            if (!auto_pend) GNT = arb_win;
            if (auto_pend || arb_any) begin
               state_nxt = ST_START;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            GNT       = gnt_q;
            RD_START  = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            GNT = gnt_q;
            if (RD_DONE || tmo) state_nxt = ST_DELIVER;
         end
         ST_DELIVER: begin
            if (auto_win) begin
               AUTO_VALID = 1'b1;
            end else begin
               RSP_VALID = gnt_q;
            end
            state_nxt = ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt == '0) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign RSP_DATA  = rsp_data;
   assign AUTO_MISS = auto_miss;

endmodule

// File: tb/tb_lm07_sample_sched.sv
// Directed bench for lm07_sample_sched (NREQ=4, PERIOD=40, GAP=4, TIMEOUT=64).
// Each scenario starts from reset so the period counter position is known:
// with release after edge E0, the first auto wrap happens at edge E40.
module tb_lm07_sample_sched;
   import lm07_sched_pkg::*;

   localparam int NREQ    = 4;
   localparam int PERIOD  = 40;
   localparam int GAP     = 4;
   localparam int TIMEOUT = 64;

   logic            SYSCLK = 1'b0;
   logic            RST = 1'b1;
   logic [NREQ-1:0] REQ = '0;
   logic [NREQ-1:0] GNT;
   logic [NREQ-1:0] RSP_VALID;
   logic [7:0]      RSP_DATA;
   logic            AUTO_VALID;
   logic            AUTO_MISS;
   logic            ERR;
   logic            RD_START;
   logic            RD_DONE = 1'b0;
   logic [7:0]      RD_DATA = '0;

   int n_cmp = 0;
   int n_err = 0;

   lm07_sample_sched #(
      .NREQ    (NREQ),
      .PERIOD  (PERIOD),
      .GAP     (GAP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .SYSCLK     (SYSCLK),
      .RST        (RST),
      .REQ        (REQ),
      .GNT        (GNT),
      .RSP_VALID  (RSP_VALID),
      .RSP_DATA   (RSP_DATA),
      .AUTO_VALID (AUTO_VALID),
      .AUTO_MISS  (AUTO_MISS),
      .ERR        (ERR),
      .RD_START   (RD_START),
      .RD_DONE    (RD_DONE),
      .RD_DATA    (RD_DATA)
   );

   always #5 SYSCLK = ~SYSCLK;

   initial begin
      #600000;
      $display("FAIL watchdog: observed no end of run, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge SYSCLK);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST     = 1'b1;
      REQ     = '0;
      RD_DONE = 1'b0;
      RD_DATA = '0;
      ticks(2);
      RST = 1'b0;
   endtask

   // Bounded wait for RD_START; an expired bound shows up as a failed check.
   task automatic wait_start(input string tag, output int waited);
      waited = 0;
      while (RD_START !== 1'b1 && waited < 300) begin
         tick();
         waited++;
      end
      chk(tag, 32'(RD_START), 32'd1);
   endtask

   // One engine transaction: wait for RD_START, answer after dly cycles, sample delivery.
   task automatic read_txn(input string tag, input logic [7:0] d, input int dly,
                           output logic [3:0] g, output logic [3:0] rv,
                           output logic [7:0] rd, output logic av, output int waited);
      wait_start(tag, waited);
      g = GNT;
      ticks(dly);
      RD_DONE = 1'b1;
      RD_DATA = d;
      tick();
      RD_DONE = 1'b0;
      rv = RSP_VALID;
      rd = RSP_DATA;
      av = AUTO_VALID;
   endtask

   initial begin
      logic [3:0] g;
      logic [3:0] rv;
      logic [7:0] rd;
      logic       av;
      int         w;
      int         cnt_a;
      int         cnt_b;
      int         cnt_c;

      // ---------------- reset values
      do_reset();
      chk("rst_gnt",   32'(GNT),        32'h0);
      chk("rst_rspv",  32'(RSP_VALID),  32'h0);
      chk("rst_data",  32'(RSP_DATA),   32'h0);
      chk("rst_autov", 32'(AUTO_VALID), 32'h0);
      chk("rst_miss",  32'(AUTO_MISS),  32'h0);
      chk("rst_err",   32'(ERR),        32'h0);
      chk("rst_start", 32'(RD_START),   32'h0);

      // ---------------- single requester, engine answers 10 cycles after RD_START
      REQ = 4'b0001;
      tick();
      chk("s_gnt_t1",   32'(GNT),      32'h1);
      chk("s_start_t1", 32'(RD_START), 32'h0);
      tick();
      chk("s_start_t2", 32'(RD_START), 32'h1);
      chk("s_gnt_t2",   32'(GNT),      32'h1);
      ticks(9);
      chk("s_norsp",    32'(RSP_VALID), 32'h0);
      RD_DONE = 1'b1;
      RD_DATA = 8'h19;
      tick();
      RD_DONE = 1'b0;
      chk("s_rspv",     32'(RSP_VALID), 32'h1);
      chk("s_data",     32'(RSP_DATA),  32'h19);
      chk("s_gnt_clr",  32'(GNT),       32'h0);
      REQ = 4'b0000;
      tick();
      chk("s_rspv_1cy", 32'(RSP_VALID), 32'h0);
      chk("s_hold",     32'(RSP_DATA),  32'h19);

      // ---------------- round robin, all four requesting
      do_reset();
      REQ = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         read_txn("rr_start", 8'h10 + 8'(k), 1, g, rv, rd, av, w);
         chk("rr_gnt",  32'(g),  32'(4'b0001 << k));
         chk("rr_rspv", 32'(rv), 32'(4'b0001 << k));
         chk("rr_data", 32'(rd), 32'(8'h10 + 8'(k)));
         if (k == 0) chk("rr_lat", 32'(w), 32'd2);
         else        chk("rr_gap", 32'(w), 32'(GAP + 3));
      end
      REQ = 4'b0000;

      // ---------------- auto slot beats requester 2 arriving with the wrap
      do_reset();
      ticks(PERIOD - 1);
      chk("ap_pre_autov", 32'(AUTO_VALID), 32'h0);
      REQ = 4'b0100;
      tick();
      chk("ap_arb_gnt", 32'(GNT), 32'h0);
      read_txn("ap_start1", 8'hA5, 2, g, rv, rd, av, w);
      chk("ap1_gnt",   32'(g),  32'h0);
      chk("ap1_autov", 32'(av), 32'h1);
      chk("ap1_rspv",  32'(rv), 32'h0);
      chk("ap1_data",  32'(rd), 32'hA5);
      read_txn("ap_start2", 8'h3C, 2, g, rv, rd, av, w);
      chk("ap2_gnt",   32'(g),  32'h4);
      chk("ap2_rspv",  32'(rv), 32'h4);
      chk("ap2_data",  32'(rd), 32'h3C);
      chk("ap2_autov", 32'(av), 32'h0);
      REQ = 4'b0000;

      // ---------------- overrun: engine stalls across two wraps
      do_reset();
      REQ = 4'b0001;
      wait_start("ov_start", w);
      ticks(77);
      chk("ov_miss_pre", 32'(AUTO_MISS), 32'h0);
      tick();
      chk("ov_miss_set", 32'(AUTO_MISS), 32'h1);
      ticks(5);
      RD_DONE = 1'b1;
      RD_DATA = 8'h81;
      tick();
      RD_DONE = 1'b0;
      chk("ov_rspv", 32'(RSP_VALID), 32'h1);
      chk("ov_sign", 32'(RSP_DATA),  32'h81);
      REQ = 4'b0000;
      read_txn("ov_auto_start", 8'h11, 1, g, rv, rd, av, w);
      chk("ov_auto_gnt",  32'(g),  32'h0);
      chk("ov_auto_v",    32'(av), 32'h1);
      chk("ov_auto_data", 32'(rd), 32'h11);
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (AUTO_VALID === 1'b1) cnt_a++;
         if (RD_START === 1'b1) cnt_b++;
      end
      chk("ov_extra_auto",  32'(cnt_a), 32'd0);
      chk("ov_extra_start", 32'(cnt_b), 32'd0);
      chk("ov_miss_sticky", 32'(AUTO_MISS), 32'h1);

      // ---------------- read timeout (or endless wait without the feature)
      do_reset();
      REQ = 4'b0010;
      wait_start("to_start", w);
`ifdef SCHED_TIMEOUT_EN
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < TIMEOUT; i++) begin
         tick();
         if (ERR === 1'b1) cnt_a++;
         if (RSP_VALID !== 4'b0000) cnt_b++;
      end
      chk("to_early_err",  32'(cnt_a), 32'd0);
      chk("to_early_rspv", 32'(cnt_b), 32'd0);
      tick();
      chk("to_err",  32'(ERR),       32'h1);
      chk("to_rspv", 32'(RSP_VALID), 32'h2);
      chk("to_fill", 32'(RSP_DATA),  32'hFF);
      REQ = 4'b0000;
      tick();
      chk("to_err_1cy", 32'(ERR), 32'h0);
`else
      cnt_a = 0;
      cnt_b = 0;
      cnt_c = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (ERR === 1'b1) cnt_a++;
         if (RSP_VALID !== 4'b0000) cnt_b++;
         if (RD_START === 1'b1) cnt_c++;
      end
      chk("nt_err",   32'(cnt_a), 32'd0);
      chk("nt_rspv",  32'(cnt_b), 32'd0);
      chk("nt_start", 32'(cnt_c), 32'd0);
      chk("nt_gnt",   32'(GNT),   32'h2);
      chk("nt_state", 32'(dut.state), 32'(ST_WAIT));
      REQ = 4'b0000;
`endif

      // ---------------- RD_DONE during START is ignored; REQ drop while granted
      do_reset();
      REQ = 4'b0100;
      wait_start("sd_start", w);
      RD_DONE = 1'b1;
      RD_DATA = 8'hEE;
      REQ     = 4'b0000;
      tick();
      RD_DONE = 1'b0;
      chk("sd_norsp", 32'(RSP_VALID), 32'h0);
      chk("sd_gnt",   32'(GNT),       32'h4);
      ticks(2);
      chk("sd_norsp2", 32'(RSP_VALID), 32'h0);
      RD_DONE = 1'b1;
      RD_DATA = 8'h42;
      tick();
      RD_DONE = 1'b0;
      chk("sd_rspv", 32'(RSP_VALID), 32'h4);
      chk("sd_data", 32'(RSP_DATA),  32'h42);

      // ---------------- reset while waiting, stray RD_DONE afterwards
      do_reset();
      REQ = 4'b0001;
      read_txn("rw_start1", 8'h5A, 1, g, rv, rd, av, w);
      chk("rw_pre_data", 32'(rd), 32'h5A);
      REQ = 4'b1000;
      wait_start("rw_start2", w);
      ticks(2);
      chk("rw_gnt_wait", 32'(GNT), 32'h8);
      RST = 1'b1;
      REQ = 4'b0000;
      tick();
      RST = 1'b0;
      chk("rw_gnt",   32'(GNT),       32'h0);
      chk("rw_start", 32'(RD_START),  32'h0);
      chk("rw_data",  32'(RSP_DATA),  32'h0);
      chk("rw_rspv",  32'(RSP_VALID), 32'h0);
      chk("rw_state", 32'(dut.state), 32'(ST_IDLE));
      ticks(2);
      RD_DONE = 1'b1;
      RD_DATA = 8'h77;
      tick();
      RD_DONE = 1'b0;
      cnt_a = (RSP_VALID !== 4'b0000) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (RSP_VALID !== 4'b0000) cnt_a++;
      end
      chk("rw_stray_rspv", 32'(cnt_a),     32'd0);
      chk("rw_stray_data", 32'(RSP_DATA),  32'h0);
      chk("rw_idle",       32'(dut.state), 32'(ST_IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
